// File: rtl/sdram_avalon_bist_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdram_avalon_bist_master_pkg
// Purpose : Shared state encodings, pattern-select codes and checkerboard
//           constants for the SDRAM Avalon BIST traffic master.
// Revision: 1.0 - initial release
// ============================================================================
package sdram_avalon_bist_master_pkg;

  // Sequencer states; REQ/ACK/CMP triplets are the watchdog-guarded ones
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_ACK = 3'd2,
    S_WR_CMP = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_ACK = 3'd5,
    S_RD_CMP = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  // Pattern-select codes
  localparam logic [1:0] c_pat_addr  = 2'd0;  // data = address
  localparam logic [1:0] c_pat_naddr = 2'd1;  // data = ~address
  localparam logic [1:0] c_pat_chk   = 2'd2;  // checkerboard by word parity
  localparam logic [1:0] c_pat_const = 2'd3;  // fixed constant word

  // Checkerboard words for even and odd word offsets
  localparam logic [31:0] c_chk_even = 32'hAAAA5555;
  localparam logic [31:0] c_chk_odd  = 32'h5555AAAA;

endpackage
`default_nettype wire

// File: rtl/sdram_avalon_bist_master_bist_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : bist_pattern_gen
// Purpose : Combinational pattern source; the same word is used as write
//           data and as the expected read data for a given word offset.
// Revision: 1.0 - initial release
// ============================================================================
module bist_pattern_gen
  import sdram_avalon_bist_master_pkg::*;
#(
  parameter int              ADDR_W    = 25,
  parameter int              DATA_W    = 32,
  parameter int              CNT_W     = 16,
  parameter logic [DATA_W-1:0] CONST_PAT = DATA_W'(32'hDEADBEEF)
) (
  input  logic [1:0]        pat_sel,
  input  logic [CNT_W-1:0]  idx,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] w_addr_ext;

  // Absolute word address zero-extended (or truncated) to the data width
  assign w_addr_ext = DATA_W'(addr);

  // Select the pattern word for this offset/address
  always_comb begin
    data = '0;
    case (pat_sel)
      c_pat_addr:  data = w_addr_ext;
      c_pat_naddr: data = ~w_addr_ext;
      c_pat_chk:   data = idx[0] ? DATA_W'(c_chk_odd) : DATA_W'(c_chk_even);
      c_pat_const: data = CONST_PAT;
      default:     data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sdram_avalon_bist_master.sv
`default_nettype none
// ============================================================================
// Module  : sdram_avalon_bist_master
// Purpose : Write/read-back memory test master for the SDRAM controller's
//           local_* port. Writes a pattern over a word range, reads it back,
//           counts mismatches and guards every handshake with a watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_avalon_bist_master
  import sdram_avalon_bist_master_pkg::*;
#(
  parameter int                ADDR_W    = 25,
  parameter int                DATA_W    = 32,
  parameter int                CNT_W     = 16,
  parameter int                TIMEOUT   = 4096,
  parameter logic [DATA_W-1:0] CONST_PAT = DATA_W'(32'hDEADBEEF)
) (
  input  logic              clk,
  input  logic              soft_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic [1:0]        pat_sel,
  input  logic              local_ready,
  input  logic              local_rddatavalid,
  input  logic [DATA_W-1:0] local_rdata,
  output logic              local_write,
  output logic              local_read,
  output logic [ADDR_W-1:0] local_addr,
  output logic [DATA_W-1:0] local_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_pat;
  logic [WD_W-1:0]   r_wdog;

  logic              r_local_write;
  logic              r_local_read;
  logic [ADDR_W-1:0] r_local_addr;
  logic [DATA_W-1:0] r_local_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_first_err_addr;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_pat;
  logic [CNT_W-1:0]  w_idx_next;
  logic              w_last;
  logic              w_mismatch;
  logic              w_hs;
  logic              w_progress;
  logic              w_wdog_exp;

  // Current word address wraps naturally at 2^ADDR_W
  assign w_addr     = r_base + ADDR_W'(r_idx);
  assign w_idx_next = r_idx + 1'b1;
  assign w_last     = (w_idx_next == r_cnt);
  // Ready without valid data is a protocol error and counts as a mismatch
  assign w_mismatch = !local_rddatavalid || (local_rdata != w_pat);
  assign w_wdog_exp = (r_wdog == WD_W'(TIMEOUT - 1));

  bist_pattern_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .CONST_PAT (CONST_PAT)
  ) u_pattern_gen (
    .pat_sel (r_pat),
    .idx     (r_idx),
    .addr    (w_addr),
    .data    (w_pat)
  );

  // Flag handshake states and whether the awaited slave condition is present
  always_comb begin
    w_hs       = 1'b1;
    w_progress = 1'b0;
    case (r_state)
      S_WR_REQ, S_RD_REQ, S_WR_CMP, S_RD_CMP: w_progress = local_ready;
      S_WR_ACK, S_RD_ACK:                     w_progress = !local_ready;
      default:                                w_hs       = 1'b0;
    endcase
  end

  // Test sequencer with registered command/status outputs and watchdog
  always_ff @(posedge clk or posedge soft_rst) begin
    if (soft_rst) begin
      r_state          <= S_IDLE;
      r_idx            <= '0;
      r_cnt            <= '0;
      r_base           <= '0;
      r_pat            <= '0;
      r_wdog           <= '0;
      r_local_write    <= 1'b0;
      r_local_read     <= 1'b0;
      r_local_addr     <= '0;
      r_local_wdata    <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_base           <= base_addr;
            r_cnt            <= word_cnt;
            r_pat            <= pat_sel;
            r_idx            <= '0;
            r_busy           <= 1'b1;
            r_state          <= (word_cnt == '0) ? S_FIN : S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (local_ready) begin
            r_local_write <= 1'b1;
            r_local_addr  <= w_addr;
            r_local_wdata <= w_pat;
            r_state       <= S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          // Ready high alone is no acceptance (refresh); hold until it falls
          if (!local_ready) begin
            r_local_write <= 1'b0;
            r_state       <= S_WR_CMP;
          end
        end
        S_WR_CMP: begin
          if (local_ready) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= S_RD_REQ;
            end else begin
              r_idx   <= w_idx_next;
              r_state <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (local_ready) begin
            r_local_read <= 1'b1;
            r_local_addr <= w_addr;
            r_state      <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (!local_ready) begin
            r_local_read <= 1'b0;
            r_state      <= S_RD_CMP;
          end
        end
        S_RD_CMP: begin
          if (local_ready) begin
            if (w_mismatch) begin
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
              end
              // Count never returns to zero once saturated, so zero means first
              if (r_err_cnt == '0) begin
                r_first_err_addr <= w_addr;
              end
            end
            if (w_last) begin
              r_idx   <= '0;
              r_state <= S_FIN;
            end else begin
              r_idx   <= w_idx_next;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_cnt == '0) && !r_timeout;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Watchdog: overrides the state update above when it expires
      if (w_hs && !w_progress) begin
        if (w_wdog_exp) begin
          r_timeout     <= 1'b1;
          r_local_write <= 1'b0;
          r_local_read  <= 1'b0;
          r_wdog        <= '0;
          r_state       <= S_FIN;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign local_write    = r_local_write;
  assign local_read     = r_local_read;
  assign local_addr     = r_local_addr;
  assign local_wdata    = r_local_wdata;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;

endmodule
`default_nettype wire

// File: doc/sdram_avalon_bist_master.md
Name: sdram_avalon_bist_master

Overview:
- Avalon-style traffic master driving the local_* slave port of the SDRAM controller's main FSM, from the initiator side.
- On start, writes a generated pattern over a word range, reads the range back and compares each word.
- Reports pass/fail, error count, first failing address and a handshake timeout.
- Sits between the board-level test/debug logic and the SDRAM controller top; used for bring-up and in-system memory test.

Parameters:
- ADDR_W, 25, local_addr width; addr[24:23] is bank, [22:10] is row, [9:0] is column.
- DATA_W, 32, local data width.
- CNT_W, 16, width of word_cnt and err_cnt.
- TIMEOUT, 4096, maximum cycles waiting in any handshake state before abort.
- CONST_PAT, 32'hDEADBEEF, data word for pattern 3.

Ports:
- clk  in  1  100 MHz system clock
- soft_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a test when idle
- base_addr  in  ADDR_W  first word address; sampled on accepted start
- word_cnt  in  CNT_W  number of words; sampled on accepted start
- pat_sel  in  2  pattern select; sampled on accepted start
- local_ready  in  1  slave idle/accepting (low during init and during an access)
- local_rddatavalid  in  1  read data valid (sticky until next read accepted)
- local_rdata  in  DATA_W  read data
- local_write  out  1  write command
- local_read  out  1  read command
- local_addr  out  ADDR_W  command address
- local_wdata  out  DATA_W  write data
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start
- pass  out  1  valid when done; 1 = no mismatch and no timeout
- timeout  out  1  handshake watchdog expired
- err_cnt  out  CNT_W  mismatch count, saturating at all-ones
- first_err_addr  out  ADDR_W  address of first mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, watchdog 0. Reset mid-test aborts immediately, with commands low on the same edge.
- Pattern, with idx = word offset and a = absolute address zero-extended to DATA_W:
  - 0: a
  - 1: ~a
  - 2: idx even gives 32'hAAAA5555, odd gives 32'h5555AAAA
  - 3: CONST_PAT
- Address: base_addr + idx, modulo 2^ADDR_W (wraps 0x1FFFFFF to 0).
- IDLE:
  - start clears done, pass, timeout, err_cnt and first_err_addr, latches the inputs and sets busy.
  - word_cnt = 0 goes directly to FIN (pass = 1).
  - Otherwise go to WR_REQ.
  - start while busy is ignored.
- WR_REQ:
  - Wait for local_ready = 1, then assert local_write with addr/wdata and go to WR_ACK.
- WR_ACK:
  - Hold the command stable until local_ready = 0 is seen.
  - The slave samples only in its idle state and ignores commands during refresh even though ready is high, so the command must be held.
  - On seeing local_ready = 0, deassert local_write on that edge and go to WR_CMP.
- WR_CMP:
  - Wait for local_ready = 1 (write complete).
  - idx++ ; if idx = word_cnt, reset idx and go to RD_REQ, else go to WR_REQ.
- RD_REQ / RD_ACK: same handshake as the write path, using local_read.
- RD_CMP:
  - On local_ready = 1 with local_rddatavalid = 1, compare local_rdata with the expected pattern for idx.
  - On mismatch: err_cnt++ (saturating); on the first mismatch also capture first_err_addr.
  - idx++ ; at word_cnt go to FIN, else go to RD_REQ.
  - local_ready = 1 with rddatavalid = 0 is a protocol error: counted as a mismatch.
- FIN:
  - busy = 0, done = 1, pass = (err_cnt == 0 && !timeout).
  - Go to IDLE.
- Watchdog:
  - Counts cycles in REQ/ACK/CMP states and clears on every state change.
  - Reaching TIMEOUT sets timeout, drops both commands and goes to FIN.
- Command exclusivity:
  - local_write and local_read are never both high.
  - Commands never go high in the same cycle another command is being dropped.
- Latency per word (ideal slave): ready wait, then 1 cycle to assert, then ack detect, then slave access.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, WR_REQ, WR_ACK, WR_CMP, RD_REQ, RD_ACK, RD_CMP, FIN)
  - pattern-select codes
  - the checkerboard constants
  - in the existing head.v include, alongside the MUX_* defines
- One sub-module, bist_pattern_gen: combinational expected/write data from (pat_sel, idx, addr).

Test Plan:
- Behavioural SDRAM controller model, ready low for 200 cycles of init, then start with base 0x0000100, word_cnt 8, pat_sel 0 -> 8 writes with data 0x100..0x107, 8 reads, done = 1, pass = 1, err_cnt = 0.
- Model corrupts the read at 0x0000103 (bit 0 flipped), pat_sel 2 -> err_cnt = 1, first_err_addr = 0x0000103, pass = 0.
- Model refreshes (ready high, not sampling) for 10 cycles while a write is pending -> command held unchanged until ready falls; exactly 8 writes are accepted and no duplicates occur.
- base_addr 0x1FFFFFE, word_cnt 4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
- Model never drops ready after a command, TIMEOUT = 64 -> timeout = 1 at 64 cycles, commands low, done = 1, pass = 0.
- Two further cases:
  - word_cnt 0 -> done with pass = 1 and no commands issued.
  - Reset asserted mid read -> all outputs 0 the same cycle; start ignored while busy.
